// File: rtl/vision_pkg.sv
// Shared frame-buffer geometry and capture FSM encoding.
package vision_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned ADDR_W   = 19;
    localparam int unsigned PIX_W    = 12;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_VS,
        WAIT_FS,
        ACTIVE
    } cap_state_e;

endpackage

// File: rtl/sync_edge.sv
// Registers one camera sync signal and derives its rise/fall pulses
// from the registered copy and a one-cycle-delayed copy.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic q_q;
    logic prev_q;

    // Input register followed by the delayed copy used for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q    <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            q_q    <= d;
            prev_q <= q_q;
        end
    end

    assign q    = q_q;
    assign rise = q_q & ~prev_q;
    assign fall = ~q_q & prev_q;

endmodule

// File: rtl/camera_capture.sv
// OV7670 RGB444 byte-stream capture into the 640x480 frame buffer write port.
module camera_capture #(
    parameter int unsigned H_ACTIVE = vision_pkg::H_ACTIVE,
    parameter int unsigned V_ACTIVE = vision_pkg::V_ACTIVE
) (
    input  logic                              pclk,
    input  logic                              reset_n,
    input  logic                              capture_en,
    input  logic                              cam_vsync,
    input  logic                              cam_href,
    input  logic [7:0]                        cam_data,
    output logic [vision_pkg::ADDR_W-1:0]     mem_addr,
    output logic [vision_pkg::PIX_W-1:0]      mem_data,
    output logic                              mem_we,
    output logic                              frame_done,
    output logic                              busy,
    output logic [7:0]                        frame_count
);

    import vision_pkg::cap_state_e, vision_pkg::IDLE, vision_pkg::WAIT_VS,
           vision_pkg::WAIT_FS, vision_pkg::ACTIVE;

    localparam logic [9:0] H_LIM = 10'(H_ACTIVE);
    localparam logic [8:0] V_LIM = 9'(V_ACTIVE);

    logic       vs_q, vs_rise, vs_fall;
    logic       hr_q, hr_rise, hr_fall;
    logic [7:0] d_q;

    cap_state_e                      state_q;
    logic [9:0]                      col_q;
    logic [8:0]                      row_q;
    logic [vision_pkg::ADDR_W-1:0]   addr_q;
    logic                            phase_q;
    logic [3:0]                      red_q;
    logic [vision_pkg::ADDR_W-1:0]   mem_addr_q;
    logic [vision_pkg::PIX_W-1:0]    mem_data_q;
    logic                            mem_we_q;
    logic                            frame_done_q;
    logic                            busy_q;
    logic [7:0]                      frame_count_q;
    logic                            first_byte_d;

    sync_edge u_vs_sync (
        .clk   (pclk),
        .rst_n (reset_n),
        .d     (cam_vsync),
        .q     (vs_q),
        .rise  (vs_rise),
        .fall  (vs_fall)
    );

    sync_edge u_hr_sync (
        .clk   (pclk),
        .rst_n (reset_n),
        .d     (cam_href),
        .q     (hr_q),
        .rise  (hr_rise),
        .fall  (hr_fall)
    );

    // Data byte register, aligned with the registered HREF/VSYNC copies.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            d_q <= '0;
        end else begin
            d_q <= cam_data;
        end
    end

    // Phase is already 0 at the start of every line; the rise term only
    // makes the first byte of a line unconditionally the red byte.
    assign first_byte_d = ~phase_q | hr_rise;

    // Frame FSM, byte assembly, counters and registered write-port outputs.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            col_q         <= '0;
            row_q         <= '0;
            addr_q        <= '0;
            phase_q       <= 1'b0;
            red_q         <= '0;
            mem_addr_q    <= '0;
            mem_data_q    <= '0;
            mem_we_q      <= 1'b0;
            frame_done_q  <= 1'b0;
            busy_q        <= 1'b0;
            frame_count_q <= '0;
        end else begin
            mem_we_q     <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= (state_q == ACTIVE);
            case (state_q)
                IDLE: begin
                    if (capture_en) state_q <= WAIT_VS;
                end
                WAIT_VS: begin
                    if (vs_q) state_q <= WAIT_FS;
                end
                WAIT_FS: begin
                    if (vs_fall) begin
                        state_q <= ACTIVE;
                        col_q   <= '0;
                        row_q   <= '0;
                        addr_q  <= '0;
                        phase_q <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (vs_rise) begin
                        // Frame end wins over a byte arriving on the same cycle.
                        frame_done_q  <= 1'b1;
                        frame_count_q <= frame_count_q + 8'd1;
                        state_q       <= capture_en ? WAIT_FS : IDLE;
                    end else if (hr_fall) begin
                        phase_q <= 1'b0;
                        if (col_q != '0) begin
                            col_q <= '0;
                            if (row_q < V_LIM) row_q <= row_q + 9'd1;
                        end
                    end else if (hr_q) begin
                        if (first_byte_d) begin
                            red_q   <= d_q[3:0];
                            phase_q <= 1'b1;
                        end else begin
                            phase_q <= 1'b0;
                            if (col_q < H_LIM) begin
                                col_q <= col_q + 10'd1;
                                if (row_q < V_LIM) begin
                                    mem_we_q   <= 1'b1;
                                    mem_addr_q <= addr_q;
                                    mem_data_q <= {red_q, d_q};
                                    addr_q     <= addr_q + 19'd1;
                                end
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_data    = mem_data_q;
    assign mem_we      = mem_we_q;
    assign frame_done  = frame_done_q;
    assign busy        = busy_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_camera_capture.sv
// Directed bench for camera_capture using a reduced 8x4 frame geometry.
module tb_camera_capture;

    localparam int unsigned TH = 8;
    localparam int unsigned TV = 4;
    localparam int unsigned LOGN = 512;

    logic        pclk;
    logic        reset_n;
    logic        capture_en;
    logic        cam_vsync;
    logic        cam_href;
    logic [7:0]  cam_data;
    logic [18:0] mem_addr;
    logic [11:0] mem_data;
    logic        mem_we;
    logic        frame_done;
    logic        busy;
    logic [7:0]  frame_count;

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    logic [18:0] log_addr [0:LOGN-1];
    logic [11:0] log_data [0:LOGN-1];
    int unsigned wr_cnt = 0;
    int unsigned fd_cnt = 0;

    camera_capture #(.H_ACTIVE(TH), .V_ACTIVE(TV)) dut (
        .pclk        (pclk),
        .reset_n     (reset_n),
        .capture_en  (capture_en),
        .cam_vsync   (cam_vsync),
        .cam_href    (cam_href),
        .cam_data    (cam_data),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_we      (mem_we),
        .frame_done  (frame_done),
        .busy        (busy),
        .frame_count (frame_count)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, required run to finish");
        $fatal(1, "watchdog");
    end

    // Write/frame_done logger, sampled on the falling edge.
    always @(negedge pclk) begin
        if (frame_done) fd_cnt++;
        if (mem_we) begin
            if (wr_cnt < LOGN) begin
                log_addr[wr_cnt] = mem_addr;
                log_data[wr_cnt] = mem_data;
            end
            wr_cnt++;
        end
    end

    function automatic logic [11:0] pix(input int unsigned r, input int unsigned c);
        return 12'(32'hA5C + r * 273 + c * 19);
    endfunction

    function automatic logic [7:0] lbyte(input int unsigned r, input int unsigned i);
        logic [11:0] p;
        logic [3:0]  cn;
        p  = pix(r, i / 2);
        cn = 4'(i / 2);
        return (i % 2 == 0) ? {cn, p[11:8]} : p[7:0];
    endfunction

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge pclk);
            #2;
        end
    endtask

    task automatic send_line(input int unsigned r, input int unsigned nbytes);
        for (int unsigned i = 0; i < nbytes; i++) begin
            cam_href = 1'b1;
            cam_data = lbyte(r, i);
            tick(1);
        end
        cam_href = 1'b0;
        cam_data = 8'h00;
        tick(4);
    endtask

    task automatic frame_open();
        cam_vsync = 1'b1;
        tick(4);
        cam_vsync = 1'b0;
        tick(3);
    endtask

    task automatic frame_close();
        cam_vsync = 1'b1;
        tick(4);
    endtask

    task automatic test_reset();
        n_cmp++; if (mem_addr !== 19'd0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", mem_addr); end
        n_cmp++; if (mem_data !== 12'h000) begin n_fail++; $display("FAIL reset_data: got %h want 000", mem_data); end
        n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", mem_we); end
        n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_fd: got %b want 0", frame_done); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (frame_count !== 8'd0) begin n_fail++; $display("FAIL reset_fc: got %0d want 0", frame_count); end
        capture_en = 1'b1;
        reset_n    = 1'b1;
        tick(2);
    endtask

    task automatic test_full_frame();
        int unsigned base, fd0;
        logic [11:0] exp;
        base = wr_cnt;
        fd0  = fd_cnt;
        frame_open();
        send_line(0, 2 * TH);
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ff_busy_mid: got %b want 1", busy); end
        for (int unsigned r = 1; r < TV; r++) send_line(r, 2 * TH);
        frame_close();
        n_cmp++; if (wr_cnt - base !== TH * TV) begin n_fail++; $display("FAIL ff_count: got %0d want %0d", wr_cnt - base, TH * TV); end
        n_cmp++; if (log_addr[base] !== 19'd0) begin n_fail++; $display("FAIL ff_first_addr: got %0d want 0", log_addr[base]); end
        n_cmp++; if (log_data[base] !== 12'hA5C) begin n_fail++; $display("FAIL ff_first_data: got %h want a5c", log_data[base]); end
        n_cmp++; if (log_addr[wr_cnt-1] !== 19'(TH * TV - 1)) begin n_fail++; $display("FAIL ff_last_addr: got %0d want %0d", log_addr[wr_cnt-1], TH * TV - 1); end
        n_cmp++; if (fd_cnt - fd0 !== 1) begin n_fail++; $display("FAIL ff_frame_done: got %0d pulses want 1", fd_cnt - fd0); end
        n_cmp++; if (frame_count !== 8'd1) begin n_fail++; $display("FAIL ff_frame_count: got %0d want 1", frame_count); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ff_busy_end: got %b want 0", busy); end
        for (int unsigned k = base; k < wr_cnt; k++) begin
            exp = pix(32'(log_addr[k]) / TH, 32'(log_addr[k]) % TH);
            n_cmp++;
            if (log_data[k] !== exp) begin
                n_fail++;
                $display("FAIL ff_data[%0d]: addr %0d got %h want %h", k - base, log_addr[k], log_data[k], exp);
            end
        end
    endtask

    task automatic test_late_release();
        int unsigned base;
        reset_n    = 1'b0;
        cam_vsync  = 1'b0;
        capture_en = 1'b1;
        tick(1);
        base = wr_cnt;
        cam_href = 1'b1;
        for (int unsigned i = 0; i < 6; i++) begin
            cam_data = lbyte(0, i);
            if (i == 3) reset_n = 1'b1;
            tick(1);
        end
        cam_href = 1'b0;
        tick(3);
        send_line(1, 2 * TH);
        send_line(2, 2 * TH);
        n_cmp++; if (wr_cnt !== base) begin n_fail++; $display("FAIL late_no_write: got %0d writes want 0", wr_cnt - base); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL late_busy: got %b want 0", busy); end
        frame_open();
        for (int unsigned r = 0; r < TV; r++) send_line(r, 2 * TH);
        frame_close();
        n_cmp++; if (wr_cnt - base !== TH * TV) begin n_fail++; $display("FAIL late_count: got %0d want %0d", wr_cnt - base, TH * TV); end
        n_cmp++; if (log_addr[base] !== 19'd0) begin n_fail++; $display("FAIL late_first_addr: got %0d want 0", log_addr[base]); end
        n_cmp++; if (log_data[base] !== 12'hA5C) begin n_fail++; $display("FAIL late_first_data: got %h want a5c", log_data[base]); end
        n_cmp++; if (frame_count !== 8'd1) begin n_fail++; $display("FAIL late_fc: got %0d want 1", frame_count); end
    endtask

    task automatic test_long_line();
        int unsigned base, s0, s1, fd0;
        base = wr_cnt;
        fd0  = fd_cnt;
        frame_open();
        send_line(0, 2 * TH);
        s0 = wr_cnt;
        send_line(1, 2 * TH + 3);
        s1 = wr_cnt;
        n_cmp++; if (s1 - s0 !== TH) begin n_fail++; $display("FAIL long_line_writes: got %0d want %0d", s1 - s0, TH); end
        send_line(2, 2 * TH);
        send_line(3, 2 * TH);
        frame_close();
        n_cmp++; if (log_addr[s1] !== 19'(2 * TH)) begin n_fail++; $display("FAIL long_next_addr: got %0d want %0d", log_addr[s1], 2 * TH); end
        n_cmp++; if (log_data[s1] !== pix(2, 0)) begin n_fail++; $display("FAIL long_next_data: got %h want %h", log_data[s1], pix(2, 0)); end
        n_cmp++; if (wr_cnt - base !== TH * TV) begin n_fail++; $display("FAIL long_total: got %0d want %0d", wr_cnt - base, TH * TV); end
        n_cmp++; if (fd_cnt - fd0 !== 1) begin n_fail++; $display("FAIL long_fd: got %0d want 1", fd_cnt - fd0); end
        n_cmp++; if (frame_count !== 8'd2) begin n_fail++; $display("FAIL long_fc: got %0d want 2", frame_count); end
    endtask

    task automatic test_extra_lines();
        int unsigned base;
        logic [18:0] amax;
        base = wr_cnt;
        frame_open();
        for (int unsigned r = 0; r < TV + 2; r++) send_line(r, 2 * TH);
        frame_close();
        amax = '0;
        for (int unsigned k = base; k < wr_cnt; k++)
            if (log_addr[k] > amax) amax = log_addr[k];
        n_cmp++; if (wr_cnt - base !== TH * TV) begin n_fail++; $display("FAIL extra_count: got %0d want %0d", wr_cnt - base, TH * TV); end
        n_cmp++; if (amax !== 19'(TH * TV - 1)) begin n_fail++; $display("FAIL extra_max_addr: got %0d want %0d", amax, TH * TV - 1); end
        n_cmp++; if (frame_count !== 8'd3) begin n_fail++; $display("FAIL extra_fc: got %0d want 3", frame_count); end
    endtask

    task automatic test_capture_drop();
        int unsigned base, fd0;
        base = wr_cnt;
        fd0  = fd_cnt;
        frame_open();
        send_line(0, 2 * TH);
        send_line(1, 2 * TH);
        capture_en = 1'b0;
        send_line(2, 2 * TH);
        send_line(3, 2 * TH);
        frame_close();
        n_cmp++; if (wr_cnt - base !== TH * TV) begin n_fail++; $display("FAIL drop_count: got %0d want %0d", wr_cnt - base, TH * TV); end
        n_cmp++; if (fd_cnt - fd0 !== 1) begin n_fail++; $display("FAIL drop_fd: got %0d want 1", fd_cnt - fd0); end
        n_cmp++; if (frame_count !== 8'd4) begin n_fail++; $display("FAIL drop_fc: got %0d want 4", frame_count); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_busy: got %b want 0", busy); end
        base = wr_cnt;
        fd0  = fd_cnt;
        frame_open();
        for (int unsigned r = 0; r < TV; r++) send_line(r, 2 * TH);
        frame_close();
        n_cmp++; if (wr_cnt - base !== 0) begin n_fail++; $display("FAIL drop_idle_writes: got %0d want 0", wr_cnt - base); end
        n_cmp++; if (fd_cnt - fd0 !== 0) begin n_fail++; $display("FAIL drop_idle_fd: got %0d want 0", fd_cnt - fd0); end
        n_cmp++; if (frame_count !== 8'd4) begin n_fail++; $display("FAIL drop_idle_fc: got %0d want 4", frame_count); end
    endtask

    task automatic test_reset_mid_frame();
        int unsigned base;
        capture_en = 1'b1;
        tick(2);
        frame_open();
        send_line(0, 2 * TH);
        cam_href = 1'b1;
        for (int unsigned i = 0; i < 6; i++) begin
            cam_data = lbyte(1, i);
            if (i < 5) tick(1);
        end
        @(posedge pclk);
        @(posedge pclk);
        #1;
        n_cmp++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL rst_pre_we: got %b want 1", mem_we); end
        n_cmp++; if (mem_addr !== 19'(TH + 2)) begin n_fail++; $display("FAIL rst_pre_addr: got %0d want %0d", mem_addr, TH + 2); end
        n_cmp++; if (frame_count !== 8'd4) begin n_fail++; $display("FAIL rst_pre_fc: got %0d want 4", frame_count); end
        reset_n = 1'b0;
        #1;
        n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b want 0", mem_we); end
        n_cmp++; if (frame_count !== 8'd0) begin n_fail++; $display("FAIL rst_fc: got %0d want 0", frame_count); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (mem_addr !== 19'd0) begin n_fail++; $display("FAIL rst_addr: got %0d want 0", mem_addr); end
        base = wr_cnt;
        for (int unsigned i = 6; i < 2 * TH; i++) begin
            cam_data = lbyte(1, i);
            if (i == 10) reset_n = 1'b1;
            tick(1);
        end
        cam_href = 1'b0;
        tick(4);
        send_line(2, 2 * TH);
        n_cmp++; if (wr_cnt !== base) begin n_fail++; $display("FAIL rst_after_writes: got %0d want 0", wr_cnt - base); end
    endtask

    initial begin
        reset_n    = 1'b0;
        capture_en = 1'b0;
        cam_vsync  = 1'b0;
        cam_href   = 1'b0;
        cam_data   = 8'h00;
        tick(3);
        test_reset();
        test_full_frame();
        test_late_release();
        test_long_line();
        test_extra_lines();
        test_capture_drop();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
